// File: rtl/ld_st_buffer.sv
// In-order load/store queue: captures operands from the CDB, waits for ROB commit on stores,
// and issues one registered data-memory request per cycle from the head only.
module ld_st_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        alloc_valid,
    input  logic        alloc_is_store,
    input  logic [4:0]  alloc_ROBEN,
    input  logic [4:0]  alloc_Qj,
    input  logic [4:0]  alloc_Qk,
    input  logic [31:0] alloc_Vj,
    input  logic [31:0] alloc_Vk,
    input  logic [31:0] alloc_imm,
    output logic        full,

    input  logic        CDB_valid,
    input  logic [4:0]  CDB_ROBEN,
    input  logic [31:0] CDB_Result,

    input  logic        commit_valid,
    input  logic [4:0]  commit_ROBEN,
    input  logic        flush,

    output logic [4:0]  DM_ROBEN,
    output logic        DM_Read_en,
    output logic        DM_Write_en,
    output logic [31:0] DM_address,
    output logic [31:0] DM_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic        is_store;
        logic [4:0]  roben;
        logic [4:0]  qj;
        logic [31:0] vj;
        logic [4:0]  qk;
        logic [31:0] vk;
        logic [31:0] imm;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [DEPTH-1:0]   committed_q, committed_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [4:0]         dm_roben_q, dm_roben_d;
    logic               dm_read_q, dm_read_d;
    logic               dm_write_q, dm_write_d;
    logic [31:0]        dm_addr_q, dm_addr_d;
    logic [31:0]        dm_data_q, dm_data_d;

    logic               alloc_ok;
    logic               issue;
    logic               cdb_hit;
    logic               commit_hit;
    entry_t             hd;
    entry_t             new_ent;

    assign full = (count_q == DEPTH_CNT);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        ent_d       = ent_q;
        valid_d     = valid_q;
        committed_d = committed_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        dm_roben_d  = dm_roben_q;
        dm_read_d   = 1'b0;
        dm_write_d  = 1'b0;
        dm_addr_d   = dm_addr_q;
        dm_data_d   = dm_data_q;
        new_ent     = '0;

        alloc_ok   = alloc_valid && !full;
        cdb_hit    = CDB_valid && (CDB_ROBEN != 5'd0);
        commit_hit = commit_valid && (commit_ROBEN != 5'd0);

        hd    = ent_q[head_q];
        issue = valid_q[head_q] && (hd.qj == 5'd0) &&
                (!hd.is_store || ((hd.qk == 5'd0) && committed_q[head_q]));

        // Wake-up and commit marking on resident entries.
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                if (cdb_hit && (ent_q[i].qj == CDB_ROBEN)) begin
                    ent_d[i].qj = 5'd0;
                    ent_d[i].vj = CDB_Result;
                end
                if (cdb_hit && (ent_q[i].qk == CDB_ROBEN)) begin
                    ent_d[i].qk = 5'd0;
                    ent_d[i].vk = CDB_Result;
                end
                if (commit_hit && (ent_q[i].roben == commit_ROBEN))
                    committed_d[i] = 1'b1;
            end
        end

        if (issue) begin
            valid_d[head_q]     = 1'b0;
            committed_d[head_q] = 1'b0;
            head_d              = head_q + PTR_W'(1);
            dm_roben_d          = hd.roben;
            dm_addr_d           = hd.vj + hd.imm;
            dm_read_d           = !hd.is_store;
            dm_write_d          = hd.is_store;
            if (hd.is_store)
                dm_data_d = hd.vk;
        end

        // Operands broadcast in the allocation cycle are captured as ready.
        if (alloc_ok) begin
            new_ent.is_store = alloc_is_store;
            new_ent.roben    = alloc_ROBEN;
            new_ent.qj       = alloc_Qj;
            new_ent.vj       = alloc_Vj;
            new_ent.qk       = alloc_Qk;
            new_ent.vk       = alloc_Vk;
            new_ent.imm      = alloc_imm;
            if (cdb_hit && (alloc_Qj == CDB_ROBEN)) begin
                new_ent.qj = 5'd0;
                new_ent.vj = CDB_Result;
            end
            if (cdb_hit && (alloc_Qk == CDB_ROBEN)) begin
                new_ent.qk = 5'd0;
                new_ent.vk = CDB_Result;
            end
            ent_d[tail_q]       = new_ent;
            valid_d[tail_q]     = 1'b1;
            committed_d[tail_q] = commit_hit && (commit_ROBEN == alloc_ROBEN);
            tail_d              = tail_q + PTR_W'(1);
        end

        count_d = count_q + CNT_W'(alloc_ok) - CNT_W'(issue);

        // Flush wins over everything computed above; DM payload keeps its last value.
        if (flush) begin
            valid_d     = '0;
            committed_d = '0;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            dm_read_d   = 1'b0;
            dm_write_d  = 1'b0;
            dm_roben_d  = dm_roben_q;
            dm_addr_d   = dm_addr_q;
            dm_data_d   = dm_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= '0;
            committed_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            dm_roben_q  <= '0;
            dm_read_q   <= 1'b0;
            dm_write_q  <= 1'b0;
            dm_addr_q   <= '0;
            dm_data_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            valid_q     <= valid_d;
            committed_q <= committed_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            dm_roben_q  <= dm_roben_d;
            dm_read_q   <= dm_read_d;
            dm_write_q  <= dm_write_d;
            dm_addr_q   <= dm_addr_d;
            dm_data_q   <= dm_data_d;
        end
    end

    // NOTE: entry payload is storage qualified by valid_q, so it is deliberately left unreset.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign DM_ROBEN    = dm_roben_q;
    assign DM_Read_en  = dm_read_q;
    assign DM_Write_en = dm_write_q;
    assign DM_address  = dm_addr_q;
    assign DM_data     = dm_data_q;

endmodule
